// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: bundles the sequencer's program-ROM and register-file
// connections.
//   master (sequencer side): drives pc, a, reg_num, reg_ce, flags, halt;
//                            receives instr, reg_out.
//   slave  (ROM / register-file side): the mirror image.
//   instr   [7:0]           ROM word at address pc (combinational)
//   reg_out [7:0]           register file read data for reg_num
//   pc      [PC_WIDTH-1:0]  program counter / ROM address
//   a       [7:0]           accumulator, register file write data
//   reg_num [3:0]           one-hot register select, 0 = none
//   reg_ce                  register file write enable
//   flags   [1:0]           {carry, zero}
//   halt                    high once HLT has executed
interface instr_sequencer_if #(
  parameter int PC_WIDTH = 6
);
  logic [7:0]          instr;
  logic [7:0]          reg_out;
  logic [PC_WIDTH-1:0] pc;
  logic [7:0]          a;
  logic [3:0]          reg_num;
  logic                reg_ce;
  logic [1:0]          flags;
  logic                halt;

  modport master (
    input  instr, reg_out,
    output pc, a, reg_num, reg_ce, flags, halt
  );

  modport slave (
    output instr, reg_out,
    input  pc, a, reg_num, reg_ce, flags, halt
  );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: three-cycle fetch/decode/execute control unit with an
// 8-bit accumulator, feeding a 4-entry register file.
//   clk     system clock, rising-edge
//   nReset  asynchronous active-low reset
//   bus     instr_sequencer_if.master (ROM data in, register file in/out,
//           pc / accumulator / flags / halt out)
module instr_sequencer #(
  parameter int PC_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  nReset,
  instr_sequencer_if.master     bus
);

  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ST  = 4'h2;
  localparam logic [3:0] OP_LD  = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t              state_reg, state_next;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic [7:0]          a_reg, a_next;
  logic [7:0]          ir_reg, ir_next;
  logic                c_reg, c_next;
  logic                z_reg, z_next;

  logic [3:0] opcode;
  logic [3:0] reg_sel;
  logic       is_reg_op;
  logic [8:0] sum9;
  logic [8:0] diff9;

  assign opcode    = ir_reg[7:4];
  assign reg_sel   = 4'b0001 << ir_reg[1:0];
  assign is_reg_op = (opcode == OP_ST) || (opcode == OP_LD) ||
                     (opcode == OP_ADD) || (opcode == OP_SUB);
  // Bit 8 of the 9-bit difference is the unsigned borrow (a < reg_out).
  assign sum9      = {1'b0, a_reg} + {1'b0, bus.reg_out};
  assign diff9     = {1'b0, a_reg} - {1'b0, bus.reg_out};

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_reg <= FETCH;
      pc_reg    <= '0;
      a_reg     <= 8'h00;
      ir_reg    <= 8'h00;
      c_reg     <= 1'b0;
      z_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      a_reg     <= a_next;
      ir_reg    <= ir_next;
      c_reg     <= c_next;
      z_reg     <= z_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    a_next      = a_reg;
    ir_next     = ir_reg;
    c_next      = c_reg;
    z_next      = z_reg;
    bus.reg_num = 4'b0000;
    bus.reg_ce  = 1'b0;

    case (state_reg)
      FETCH: begin
        ir_next    = bus.instr;
        pc_next    = pc_reg + PC_WIDTH'(1);
        state_next = DECODE;
      end
      DECODE: begin
        // Select goes out a full cycle early so the read data has settled
        // by the edge that ends EXEC.
        if (is_reg_op) bus.reg_num = reg_sel;
        state_next = EXEC;
      end
      EXEC: begin
        if (is_reg_op) bus.reg_num = reg_sel;
        state_next = FETCH;
        case (opcode)
          OP_LDI: begin
            a_next = {4'b0000, ir_reg[3:0]};
            z_next = (ir_reg[3:0] == 4'h0);
          end
          OP_ST: bus.reg_ce = 1'b1;
          OP_LD: begin
            a_next = bus.reg_out;
            z_next = (bus.reg_out == 8'h00);
          end
          OP_ADD: begin
            a_next = sum9[7:0];
            c_next = sum9[8];
            z_next = (sum9[7:0] == 8'h00);
          end
          OP_SUB: begin
            a_next = diff9[7:0];
            c_next = diff9[8];
            z_next = (diff9[7:0] == 8'h00);
          end
          OP_JMP: pc_next = PC_WIDTH'(ir_reg[3:0]);
          OP_JZ:  if (z_reg) pc_next = PC_WIDTH'(ir_reg[3:0]);
          OP_HLT: state_next = HALT;
          default: ;  // NOP and the unused opcodes 0x8-0xE
        endcase
      end
      HALT: ;         // absorbing: everything holds until reset
      default: state_next = FETCH;
    endcase
  end

  assign bus.pc    = pc_reg;
  assign bus.a     = a_reg;
  assign bus.flags = {c_reg, z_reg};
  assign bus.halt  = (state_reg == HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  logic rf_clear = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [7:0] rom [64];
  logic [7:0] regs [4];
  int         ce_cycles;

  instr_sequencer_if #(.PC_WIDTH(6)) bus ();

  instr_sequencer #(.PC_WIDTH(6)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // ROM and register file models
  assign bus.instr = rom[bus.pc];

  always_comb begin
    bus.reg_out = 8'h00;
    case (bus.reg_num)
      4'b0001: bus.reg_out = regs[0];
      4'b0010: bus.reg_out = regs[1];
      4'b0100: bus.reg_out = regs[2];
      4'b1000: bus.reg_out = regs[3];
      default: bus.reg_out = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
      ce_cycles <= 0;
    end else if (bus.reg_ce) begin
      ce_cycles <= ce_cycles + 1;
      case (bus.reg_num)
        4'b0001: regs[0] <= bus.a;
        4'b0010: regs[1] <= bus.a;
        4'b0100: regs[2] <= bus.a;
        4'b1000: regs[3] <= bus.a;
        default: ;
      endcase
    end
  end

  typedef struct {
    logic [0:7][7:0] prog;
    int              n;
    logic [7:0]      a;
    logic [1:0]      flags;
    logic [5:0]      pc;
    logic            halt;
    logic [31:0]     regs;
    int              st;
  } vec_t;

  vec_t vecs [11];
  vec_t exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [0:7][7:0] p);
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    for (int i = 0; i < 8; i++) rom[i] = p[i];
  endtask

  // Reset for one full clock; release on a falling edge so the next
  // rising edge ends the first FETCH.
  task automatic do_reset(input logic clear_rf);
    @(negedge clk);
    nReset   = 1'b0;
    rf_clear = clear_rf;
    @(negedge clk);
    nReset   = 1'b1;
    rf_clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    int   err0;
    vecs[0]  = '{prog:{8'h15,8'h20,8'h17,8'h21,8'h00,8'h00,8'h00,8'h00}, n:4,
                 a:8'h07, flags:2'b00, pc:6'd4, halt:1'b0, regs:32'h00000705, st:2};
    vecs[1]  = '{prog:{8'h1F,8'h20,8'h1F,8'h40,8'h00,8'h00,8'h00,8'h00}, n:4,
                 a:8'h1E, flags:2'b00, pc:6'd4, halt:1'b0, regs:32'h0000000F, st:1};
    vecs[2]  = '{prog:{8'h1F,8'h20,8'h1F,8'h40,8'h20,8'h50,8'h00,8'h00}, n:6,
                 a:8'h00, flags:2'b01, pc:6'd6, halt:1'b0, regs:32'h0000001E, st:2};
    vecs[3]  = '{prog:{8'h1F,8'h20,8'h1F,8'h40,8'h20,8'h50,8'h11,8'h50}, n:8,
                 a:8'hE3, flags:2'b10, pc:6'd8, halt:1'b0, regs:32'h0000001E, st:2};
    vecs[4]  = '{prog:{8'h10,8'h73,8'h1F,8'h00,8'h00,8'h00,8'h00,8'h00}, n:2,
                 a:8'h00, flags:2'b01, pc:6'd3, halt:1'b0, regs:32'h00000000, st:0};
    vecs[5]  = '{prog:{8'h10,8'h73,8'h1F,8'h00,8'h00,8'h00,8'h00,8'h00}, n:3,
                 a:8'h00, flags:2'b01, pc:6'd4, halt:1'b0, regs:32'h00000000, st:0};
    vecs[6]  = '{prog:{8'h11,8'h73,8'h1F,8'h00,8'h00,8'h00,8'h00,8'h00}, n:3,
                 a:8'h0F, flags:2'b00, pc:6'd3, halt:1'b0, regs:32'h00000000, st:0};
    vecs[7]  = '{prog:{8'h6A,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, n:1,
                 a:8'h00, flags:2'b00, pc:6'd10, halt:1'b0, regs:32'h00000000, st:0};
    vecs[8]  = '{prog:{8'h19,8'h22,8'h10,8'h32,8'h00,8'h00,8'h00,8'h00}, n:4,
                 a:8'h09, flags:2'b00, pc:6'd4, halt:1'b0, regs:32'h00090000, st:1};
    vecs[9]  = '{prog:{8'h15,8'h8F,8'h30,8'h00,8'h00,8'h00,8'h00,8'h00}, n:3,
                 a:8'h00, flags:2'b01, pc:6'd3, halt:1'b0, regs:32'h00000000, st:0};
    vecs[10] = '{prog:{8'h15,8'hF0,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, n:2,
                 a:8'h05, flags:2'b00, pc:6'd2, halt:1'b1, regs:32'h00000000, st:0};

    // Power-on reset, release at 6 ns, first fetches and first ST select
    load(vecs[0].prog);
    #1;
    check("rst_pc", 32'(bus.pc), 32'd0);
    check("rst_a", 32'(bus.a), 32'h0);
    check("rst_regnum", 32'(bus.reg_num), 32'h0);
    check("rst_regce", 32'(bus.reg_ce), 32'h0);
    check("rst_flags", 32'(bus.flags), 32'h0);
    check("rst_halt", 32'(bus.halt), 32'h0);
    #5;
    nReset = 1'b1;
    rf_clear = 1'b0;
    @(negedge clk); check("fetch0_pc", 32'(bus.pc), 32'd0);
    @(negedge clk); check("after_fetch0_pc", 32'(bus.pc), 32'd1);
    repeat (3) @(negedge clk);
    check("st_decode_regnum", 32'(bus.reg_num), 32'h1);
    check("st_decode_regce", 32'(bus.reg_ce), 32'h0);
    @(negedge clk);
    check("st_exec_regnum", 32'(bus.reg_num), 32'h1);
    check("st_exec_regce", 32'(bus.reg_ce), 32'h1);
    @(negedge clk);
    check("after_st_regnum", 32'(bus.reg_num), 32'h0);
    check("after_st_regce", 32'(bus.reg_ce), 32'h0);
    $display("seq power_on_reset done, errors so far %0d", n_err);

    // Table-driven program runs through the scoreboard queue
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(vecs[i]);
      load(vecs[i].prog);
      do_reset(1'b1);
      repeat (3 * vecs[i].n) @(negedge clk);
      e = exp_q.pop_front();
      err0 = n_err;
      check($sformatf("v%0d_a", i), 32'(bus.a), 32'(e.a));
      check($sformatf("v%0d_flags", i), 32'(bus.flags), 32'(e.flags));
      check($sformatf("v%0d_pc", i), 32'(bus.pc), 32'(e.pc));
      check($sformatf("v%0d_halt", i), 32'(bus.halt), 32'(e.halt));
      check($sformatf("v%0d_regs", i), {regs[3], regs[2], regs[1], regs[0]}, e.regs);
      check($sformatf("v%0d_st_cycles", i), 32'(ce_cycles), 32'(e.st));
      $display("vector %0d: %0d instr a=%h flags=%b pc=%0d, %0d new errors",
               i, e.n, bus.a, bus.flags, bus.pc, n_err - err0);
    end

    // PC wrap with an all-NOP ROM
    load({8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00});
    do_reset(1'b1);
    repeat (186) @(negedge clk); check("wrap_pc62", 32'(bus.pc), 32'd62);
    repeat (3) @(negedge clk);   check("wrap_pc63", 32'(bus.pc), 32'd63);
    repeat (3) @(negedge clk);   check("wrap_pc0", 32'(bus.pc), 32'd0);
    $display("seq pc_wrap done, errors so far %0d", n_err);

    // HLT freezes, then reset drops Halt asynchronously
    load(vecs[10].prog);
    do_reset(1'b1);
    repeat (6) @(negedge clk);
    check("hlt_halt", 32'(bus.halt), 32'h1);
    repeat (12) @(negedge clk);
    check("hlt_frozen_pc", 32'(bus.pc), 32'd2);
    check("hlt_frozen_a", 32'(bus.a), 32'h05);
    check("hlt_frozen_halt", 32'(bus.halt), 32'h1);
    check("hlt_regce", 32'(bus.reg_ce), 32'h0);
    #2 nReset = 1'b0;
    #1;
    check("hlt_async_rst_halt", 32'(bus.halt), 32'h0);
    check("hlt_async_rst_pc", 32'(bus.pc), 32'd0);
    @(negedge clk);
    nReset = 1'b1;
    $display("seq halt_and_reset done, errors so far %0d", n_err);

    // Reset in the middle of an ST's EXEC cancels the write
    load({8'h15,8'h20,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00});
    do_reset(1'b1);
    repeat (5) @(negedge clk);
    check("midst_regce_before", 32'(bus.reg_ce), 32'h1);
    #2 nReset = 1'b0;
    #1;
    check("midst_regce_async", 32'(bus.reg_ce), 32'h0);
    check("midst_regnum_async", 32'(bus.reg_num), 32'h0);
    check("midst_a_async", 32'(bus.a), 32'h0);
    @(negedge clk);
    check("midst_r0_unchanged", 32'(regs[0]), 32'h0);
    nReset = 1'b1;
    $display("seq reset_mid_st done, errors so far %0d", n_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
